// File: rtl/reg_file_sb.sv
// Register file with two registered read ports, two write ports (C = ALU, D = load,
// D has priority), write-first bypass and a per-register busy scoreboard.

module reg_file_sb_entry #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [DATA_W-1:0] wdata,
  input  logic              set,
  output logic [DATA_W-1:0] data_o,
  output logic              busy_o
);
  logic [DATA_W-1:0] data_q, data_d;
  logic              busy_q, busy_d;

  always_comb begin
    data_d = we ? wdata : data_q;
    // a new reservation outranks a completing write to the same register
    busy_d = set ? 1'b1 : (we ? 1'b0 : busy_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      busy_q <= 1'b0;
    end else begin
      data_q <= data_d;
      busy_q <= busy_d;
    end
  end

  assign data_o = data_q;
  assign busy_o = busy_q;
endmodule

module reg_file_sb_rport #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 0,
  localparam int DEPTH   = 1 << ADDR_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         r_en,
  input  logic [ADDR_W-1:0]            raddr,
  input  logic [DEPTH-1:0][DATA_W-1:0] mem,
  input  logic [DEPTH-1:0]             busy,
  input  logic                         wc_ok,
  input  logic [ADDR_W-1:0]            rc,
  input  logic [DATA_W-1:0]            dataC,
  input  logic                         wd_ok,
  input  logic [ADDR_W-1:0]            rd,
  input  logic [DATA_W-1:0]            dataD,
  input  logic                         rs_ok,
  input  logic [ADDR_W-1:0]            res_addr,
  output logic [DATA_W-1:0]            data_o,
  output logic                         busy_o
);
  logic [DATA_W-1:0] data_q, data_d;
  logic              busy_q, busy_d;

  // Captured values reflect the register state as it stands after this edge.
  always_comb begin
    data_d = mem[raddr];
    busy_d = busy[raddr];
    if (wc_ok && rc == raddr) begin
      data_d = dataC;
      busy_d = 1'b0;
    end
    if (wd_ok && rd == raddr) begin
      data_d = dataD;
      busy_d = 1'b0;
    end
    if (rs_ok && res_addr == raddr) busy_d = 1'b1;
    if (ZERO_REG != 0 && raddr == '0) begin
      data_d = '0;
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      busy_q <= 1'b0;
    end else if (r_en) begin
      data_q <= data_d;
      busy_q <= busy_d;
    end
  end

  assign data_o = data_q;
  assign busy_o = busy_q;
endmodule

module reg_file_sb #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r_en,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  output logic [DATA_W-1:0] dataA,
  output logic [DATA_W-1:0] dataB,
  output logic              busyA,
  output logic              busyB,
  input  logic              w_en,
  input  logic [ADDR_W-1:0] rc,
  input  logic [DATA_W-1:0] dataC,
  input  logic              w2_en,
  input  logic [ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0] dataD,
  input  logic              res_en,
  input  logic [ADDR_W-1:0] res_addr
);
  localparam int DEPTH = 1 << ADDR_W;

  logic                         wc_ok, wd_ok, rs_ok;
  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [DEPTH-1:0]             busy;
  logic [1:0][ADDR_W-1:0]       raddr;
  logic [1:0][DATA_W-1:0]       rdata;
  logic [1:0]                   rbusy;

  // Register 0 is hard-wired when ZERO_REG is set: qualify every update to it away.
  assign wc_ok = w_en   && !(ZERO_REG != 0 && rc       == '0);
  assign wd_ok = w2_en  && !(ZERO_REG != 0 && rd       == '0);
  assign rs_ok = res_en && !(ZERO_REG != 0 && res_addr == '0);

  for (genvar i = 0; i < DEPTH; i++) begin : g_reg
    logic hit_c, hit_d;
    assign hit_c = wc_ok && rc == ADDR_W'(i);
    assign hit_d = wd_ok && rd == ADDR_W'(i);

    reg_file_sb_entry #(.DATA_W(DATA_W)) u_entry (
      .clk    (clk),
      .rst_n  (rst_n),
      .we     (hit_c | hit_d),
      .wdata  (hit_d ? dataD : dataC),
      .set    (rs_ok && res_addr == ADDR_W'(i)),
      .data_o (mem[i]),
      .busy_o (busy[i])
    );
  end

  assign raddr = {rb, ra};

  for (genvar p = 0; p < 2; p++) begin : g_rport
    reg_file_sb_rport #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
    ) u_rport (
      .clk      (clk),
      .rst_n    (rst_n),
      .r_en     (r_en),
      .raddr    (raddr[p]),
      .mem      (mem),
      .busy     (busy),
      .wc_ok    (wc_ok),
      .rc       (rc),
      .dataC    (dataC),
      .wd_ok    (wd_ok),
      .rd       (rd),
      .dataD    (dataD),
      .rs_ok    (rs_ok),
      .res_addr (res_addr),
      .data_o   (rdata[p]),
      .busy_o   (rbusy[p])
    );
  end

  assign dataA = rdata[0];
  assign dataB = rdata[1];
  assign busyA = rbusy[0];
  assign busyB = rbusy[1];
endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the 16x16 processor register file.
- Two synchronous read ports, two write ports and a per-register busy scoreboard, with write-to-read bypass.
- Sits between decode (reads, reservations) and writeback (ALU port C, load port D); issue stalls on busy flags.

Parameters:
- DATA_W, 16, register width in bits.
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W registers.
- ZERO_REG, 0; when 1, register 0 reads as zero, ignores writes and is never busy.

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  reset; asynchronous, active-low
r_en  in  1  read enable for both read ports
ra  in  ADDR_W  read address A
rb  in  ADDR_W  read address B
dataA  out  DATA_W  registered read data A
dataB  out  DATA_W  registered read data B
busyA  out  1  registered busy flag of ra, captured with dataA
busyB  out  1  registered busy flag of rb, captured with dataB
w_en  in  1  write enable, port C (ALU writeback)
rc  in  ADDR_W  write address, port C
dataC  in  DATA_W  write data, port C
w2_en  in  1  write enable, port D (load writeback)
rd  in  ADDR_W  write address, port D
dataD  in  DATA_W  write data, port D
res_en  in  1  reserve: mark register res_addr busy
res_addr  in  ADDR_W  register to reserve

Behaviour:
- Reset: rst_n low asynchronously clears all DEPTH registers, dataA, dataB, busyA, busyB and all busy bits to 0; these hold 0 until the first clk edge after rst_n rises. Reset mid-operation discards pending writes and reservations.
- Read latency is 1 cycle: on an edge with r_en=1, dataA/busyA capture the value of ra (dataB/busyB of rb); with r_en=0 all four outputs hold.
- Write: on an edge, w_en writes dataC to rc and w2_en writes dataD to rd.
- Both write ports enabled with rc==rd: port D wins; dataD is stored.
- Bypass (write-first): if r_en and a read address matches an enabled write address in the same cycle, the read captures that write data (port D priority if both match), not the old array value.
- Scoreboard: a busy bit per register.
  - res_en sets busy[res_addr].
  - Any enabled write clears busy of its address.
  - Reserve and write to the same address in one cycle: reserve wins, bit ends 1 (new producer).
  - Read-side busy flag reflects the post-edge value: matching write clears it, matching reserve sets it, reserve dominant.
- ZERO_REG=1:
  - Reads of address 0 return 0 and busy 0, bypass included.
  - Writes and reservations to 0 have no effect.
- Simultaneous read of the same address on A and B is legal; both ports return identical values.
- No back-pressure: every enabled operation completes in its cycle.

Test Plan:
- Reset: write 0x1234 to r5, assert rst_n low between edges -> dataA/dataB 0 immediately; read r5 after release -> 0x0000.
- Basic: write r3=0xBEEF on port C; next cycle r_en, ra=3, rb=3 -> one cycle later dataA=dataB=0xBEEF; r_en=0 afterwards -> outputs hold 0xBEEF.
- Bypass/priority: same cycle w_en rc=7 dataC=0x1111, w2_en rd=7 dataD=0x2222, r_en ra=7 -> dataA=0x2222 next cycle; later read r7 -> 0x2222.
- Scoreboard: res_en r9 -> read r9 busyA=1; port D writes r9 0xAAAA with r_en ra=9 same cycle -> dataA=0xAAAA, busyA=0; reserve and write r9 together -> busy stays 1.
- ZERO_REG=1: write 0xFFFF to r0 and reserve r0 -> reads of r0 give dataA=0, busyA=0, including the same-cycle bypass case.
- Params: DATA_W=32, ADDR_W=5 -> write r31=0xDEADBEEF, read back on port B; r0..r30 unaffected.
